rv_prog_loader: RTL and testbench
=================================

// Module: rv_prog_loader
// PURPOSE
//  Host-side program loader directly upstream of the RISC-V overlay core.
//  Parses a 32-bit word stream from the host and generates the core's
//  imem_wr_*/dmem_wr_* write strobes and its pc_valid_i/pc_start_minus4 inputs.
//  The core stays halted until a START frame has been accepted.
// PARAMETERS
//  XLEN        32     data/address width (= RV_BIT_NUM)
//  CNT_W       16     frame word-count width
//  IMEM_BYTES  16384  IMEM byte size; writes at or above it are dropped
//  DMEM_BYTES  16384  DMEM byte size; writes at or above it are dropped
// PORTS
//  clk              in   1     clock, all logic on rising edge
//  rst              in   1     asynchronous reset, active-high
//  host_data_i      in   XLEN  host stream word
//  host_valid_i     in   1     host word valid
//  host_ready_o     out  1     loader accepts; transfer = valid & ready
//  imem_wr_addr     out  XLEN  IMEM byte address, bits[1:0] = 0
//  imem_wr_data     out  XLEN  IMEM write data
//  imem_wr_valid    out  1     IMEM write strobe, 1 cycle per word
//  dmem_wr_addr     out  XLEN  DMEM byte address, bits[1:0] = 0
//  dmem_wr_data     out  XLEN  DMEM write data
//  dmem_wr_valid    out  1     DMEM write strobe, 1 cycle per word
//  pc_valid_o       out  1     level; drives core pc_valid_i
//  pc_start_minus4  out  XLEN  start PC minus 4, mod 2^XLEN
//  busy_o           out  1     high while inside a frame (state != S_HDR)
//  err_o            out  1     sticky error flag
// BEHAVIOUR
//  Reset values: all outputs 0, including host_ready_o. host_ready_o goes
//   high on the first clock after rst deasserts.
//  host_ready_o stays high in every state. Throughput is 1 word/cycle.
//  Frame = header, address word, then payload.
//   Header bits [31:30] cmd: 00 IMEM, 01 DMEM, 10 START, 11 NOP.
//   Header bits [CNT_W-1:0] = N.
//  FSM states: S_HDR -> S_ADDR -> S_DATA -> (S_CSUM) -> S_HDR.
//   NOP header: consumed, FSM stays in S_HDR.
//   START: address word is start PC, then return to S_HDR.
//   IMEM/DMEM with N=0: S_ADDR goes straight to S_HDR (or S_CSUM if enabled).
//  Data word i accepted in cycle t: in cycle t+1 the target *_wr_valid=1,
//   addr = base + 4*i (bits[1:0] forced 0), data = that word.
//   Outputs are registered, latency 1. Address wraps mod 2^XLEN.
//  Range check: addr >= IMEM_BYTES / DMEM_BYTES suppresses that strobe and
//   sets err_o. The frame continues to consume its remaining words.
//  Base address with bits[1:0] != 0: sets err_o, and the write proceeds aligned.
//  START accepted with err_o=0: next cycle pc_start_minus4 = addr-4
//   (0 -> 32'hFFFFFFFC) and pc_valid_o = 1, held.
//  START accepted with err_o=1: ignored, pc_valid_o remains 0.
//  An IMEM/DMEM header accepted while pc_valid_o=1 clears pc_valid_o on the
//   next cycle (core halted before its memory is rewritten).
//  err_o is cleared only by rst.
//  host_valid_i low mid-frame: FSM holds, no timeout.
//  rst mid-frame: frame abandoned, return to S_HDR; host must resend the
//   whole frame.
// CONFIGURATION
//  LDR_CHECKSUM_EN defined:
//   - IMEM/DMEM frames carry one trailing word in S_CSUM: the sum
//     mod 2^XLEN of the N data words.
//   - Mismatch sets err_o.
//   - Data writes are still issued (not withheld).
//  LDR_CHECKSUM_EN undefined: no S_CSUM state, no trailing word.
// TESTING
//  1. Reset, then stream 0x0000_0003, 0x0000_0100, A, B, C -> imem writes
//     (0x100,A), (0x104,B), (0x108,C) on consecutive cycles, each 1 cycle
//     after its accept; dmem_wr_valid stays 0.
//  2. 0x8000_0000, 0x0000_0200 -> pc_start_minus4 = 0x1FC, pc_valid_o = 1
//     held; then header 0x4000_0001 -> pc_valid_o falls the next cycle.
//  3. DMEM header N=2 at base 0x3FFC, DMEM_BYTES=16384 -> first write issued
//     at 0x3FFC; second (0x4000) suppressed; err_o = 1; a later START is
//     ignored.
//  4. Gaps: host_valid_i toggles 1/0 in an N=4 frame -> exactly 4 strobes,
//     correct addresses. rst mid-data -> no further strobes; fresh frame
//     loads correctly.
//  5. START to address 0 -> pc_start_minus4 = 0xFFFF_FFFC. NOP header
//     0xC000_0005 -> no strobes, busy_o stays 0.
//  6. LDR_CHECKSUM_EN: N=2 frame with data 1,2 and checksum 3 -> err_o = 0.
//     Same frame with checksum 4 -> err_o = 1 after the checksum word.

Source files
------------

// File: rtl/rv_prog_loader.sv
// ============================================================================
// rv_prog_loader
// ----------------------------------------------------------------------------
// Host-side program loader sitting directly in front of the RISC-V overlay
// core. It parses a 32-bit word stream from the host into frames, produces
// the core's instruction/data memory write strobes, and releases the core
// (pc_valid_o) once a START frame has been accepted without any prior error.
//
// Frame layout: header word, address word, then payload words.
//   header[31:30] : 00 IMEM, 01 DMEM, 10 START, 11 NOP
//   header[CNT_W-1:0] : payload word count N
//
// Optional feature macro: LDR_CHECKSUM_EN
//   When defined, every IMEM/DMEM frame carries one trailing checksum word
//   (sum mod 2^XLEN of the N data words); a mismatch sets err_o. Writes are
//   still issued as the data arrives.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   asynchronous reset, active-high
//   host_data_i      in   host stream word
//   host_valid_i     in   host word valid
//   host_ready_o     out  loader ready (transfer = valid & ready)
//   imem_wr_addr     out  IMEM byte address, word aligned
//   imem_wr_data     out  IMEM write data
//   imem_wr_valid    out  IMEM write strobe, one cycle per word
//   dmem_wr_addr     out  DMEM byte address, word aligned
//   dmem_wr_data     out  DMEM write data
//   dmem_wr_valid    out  DMEM write strobe, one cycle per word
//   pc_valid_o       out  level, core may run
//   pc_start_minus4  out  start PC minus 4, mod 2^XLEN
//   busy_o           out  high while inside a frame
//   err_o            out  sticky error flag, cleared only by rst
// ============================================================================
module rv_prog_loader #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int IMEM_BYTES = 16384,
    parameter int DMEM_BYTES = 16384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] host_data_i,
    input  logic            host_valid_i,
    output logic            host_ready_o,
    output logic [XLEN-1:0] imem_wr_addr,
    output logic [XLEN-1:0] imem_wr_data,
    output logic            imem_wr_valid,
    output logic [XLEN-1:0] dmem_wr_addr,
    output logic [XLEN-1:0] dmem_wr_data,
    output logic            dmem_wr_valid,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_start_minus4,
    output logic            busy_o,
    output logic            err_o
);

`ifdef LDR_CHECKSUM_EN
    typedef enum logic [1:0] {S_HDR, S_ADDR, S_DATA, S_CSUM} stateT;
`else
    typedef enum logic [1:0] {S_HDR, S_ADDR, S_DATA} stateT;
`endif

    localparam logic [1:0] CMD_IMEM  = 2'b00;
    localparam logic [1:0] CMD_DMEM  = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;
    localparam logic [1:0] CMD_NOP   = 2'b11;

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
    localparam logic [XLEN-1:0] DMEM_LIMIT = XLEN'(DMEM_BYTES);

    stateT            state;
    logic [1:0]       cmd;
    logic [CNT_W-1:0] wordsLeft;
    logic [XLEN-1:0]  wrAddr;
    logic             hostReady;
    logic             accept;
`ifdef LDR_CHECKSUM_EN
    logic [XLEN-1:0]  csumAcc;
`endif

    assign accept       = host_valid_i & hostReady;
    assign host_ready_o = hostReady;
    assign busy_o       = (state != S_HDR);

    // Single frame-parsing state machine. The write strobes are pulsed for
    // exactly one cycle after the data word is accepted, so they default to
    // zero every cycle. wordsLeft counts down the payload; wrAddr is the
    // aligned byte address of the next payload word and simply wraps.
    // An out-of-range write is dropped and flagged, but the frame keeps
    // consuming its words so the host stream stays in frame sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_HDR;
            cmd             <= CMD_NOP;
            wordsLeft       <= '0;
            wrAddr          <= '0;
            hostReady       <= 1'b0;
            imem_wr_addr    <= '0;
            imem_wr_data    <= '0;
            imem_wr_valid   <= 1'b0;
            dmem_wr_addr    <= '0;
            dmem_wr_data    <= '0;
            dmem_wr_valid   <= 1'b0;
            pc_valid_o      <= 1'b0;
            pc_start_minus4 <= '0;
            err_o           <= 1'b0;
`ifdef LDR_CHECKSUM_EN
            csumAcc         <= '0;
`endif
        end else begin
            hostReady     <= 1'b1;
            imem_wr_valid <= 1'b0;
            dmem_wr_valid <= 1'b0;
            if (accept) begin
                case (state)
                    S_HDR: begin
                        cmd       <= host_data_i[XLEN-1:XLEN-2];
                        wordsLeft <= host_data_i[CNT_W-1:0];
                        if (host_data_i[XLEN-1:XLEN-2] != CMD_NOP) begin
                            state <= S_ADDR;
                        end
                        // Halt the core before its memory gets rewritten.
                        if (host_data_i[XLEN-1:XLEN-2] == CMD_IMEM ||
                            host_data_i[XLEN-1:XLEN-2] == CMD_DMEM) begin
                            pc_valid_o <= 1'b0;
                        end
                    end
                    S_ADDR: begin
                        if (cmd == CMD_START) begin
                            if (!err_o) begin
                                pc_start_minus4 <= host_data_i - WORD_BYTES;
                                pc_valid_o      <= 1'b1;
                            end
                            state <= S_HDR;
                        end else begin
                            wrAddr <= {host_data_i[XLEN-1:2], 2'b00};
                            if (host_data_i[1:0] != 2'b00) begin
                                err_o <= 1'b1;
                            end
`ifdef LDR_CHECKSUM_EN
                            csumAcc <= '0;
                            state   <= (wordsLeft == '0) ? S_CSUM : S_DATA;
`else
                            state   <= (wordsLeft == '0) ? S_HDR : S_DATA;
`endif
                        end
                    end
                    S_DATA: begin
                        if (cmd == CMD_IMEM) begin
                            if (wrAddr < IMEM_LIMIT) begin
                                imem_wr_valid <= 1'b1;
                                imem_wr_addr  <= wrAddr;
                                imem_wr_data  <= host_data_i;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else begin
                            if (wrAddr < DMEM_LIMIT) begin
                                dmem_wr_valid <= 1'b1;
                                dmem_wr_addr  <= wrAddr;
                                dmem_wr_data  <= host_data_i;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                        wrAddr    <= wrAddr + WORD_BYTES;
                        wordsLeft <= wordsLeft - 1'b1;
`ifdef LDR_CHECKSUM_EN
                        csumAcc <= csumAcc + host_data_i;
                        if (wordsLeft == CNT_W'(1)) begin
                            state <= S_CSUM;
                        end
`else
                        if (wordsLeft == CNT_W'(1)) begin
                            state <= S_HDR;
                        end
`endif
                    end
`ifdef LDR_CHECKSUM_EN
                    S_CSUM: begin
                        if (host_data_i != csumAcc) begin
                            err_o <= 1'b1;
                        end
                        state <= S_HDR;
                    end
`endif
                    default: begin
                        state <= S_HDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_prog_loader.sv
// ============================================================================
// tb_rv_prog_loader
// ----------------------------------------------------------------------------
// Directed self-checking bench for rv_prog_loader. Words are driven just
// after a rising edge and outputs are sampled 1 time unit after the next
// rising edge, i.e. in the cycle following the accept.
// ============================================================================
module tb_rv_prog_loader;

    logic        clk;
    logic        rst;
    logic [31:0] host_data_i;
    logic        host_valid_i;
    logic        host_ready_o;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        imem_wr_valid;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_wr_valid;
    logic        pc_valid_o;
    logic [31:0] pc_start_minus4;
    logic        busy_o;
    logic        err_o;

    int checkCount;
    int passCount;
    int strobeCount;

    rv_prog_loader dut (
        .clk             (clk),
        .rst             (rst),
        .host_data_i     (host_data_i),
        .host_valid_i    (host_valid_i),
        .host_ready_o    (host_ready_o),
        .imem_wr_addr    (imem_wr_addr),
        .imem_wr_data    (imem_wr_data),
        .imem_wr_valid   (imem_wr_valid),
        .dmem_wr_addr    (dmem_wr_addr),
        .dmem_wr_data    (dmem_wr_data),
        .dmem_wr_valid   (dmem_wr_valid),
        .pc_valid_o      (pc_valid_o),
        .pc_start_minus4 (pc_start_minus4),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one word, let it be accepted on the next edge, then land just
    // after that edge where its registered effects are visible.
    task automatic applyStimulus(input logic [31:0] word);
        host_valid_i = 1'b1;
        host_data_i  = word;
        @(posedge clk);
        #1;
    endtask

    // One cycle with no valid word.
    task automatic idleCycle();
        host_valid_i = 1'b0;
        host_data_i  = 32'h0;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full reset pulse, returning with the loader ready.
    task automatic doReset();
        host_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering loading, START handling, gaps, resets,
    // range errors and (when built in) the trailing checksum.
    initial begin
        checkCount   = 0;
        passCount    = 0;
        strobeCount  = 0;
        rst          = 1'b1;
        host_valid_i = 1'b0;
        host_data_i  = 32'h0;

        @(posedge clk);
        #1;
        checkOutput("rst_ready",   {31'b0, host_ready_o},  32'h0);
        checkOutput("rst_imemv",   {31'b0, imem_wr_valid}, 32'h0);
        checkOutput("rst_dmemv",   {31'b0, dmem_wr_valid}, 32'h0);
        checkOutput("rst_pcvalid", {31'b0, pc_valid_o},    32'h0);
        checkOutput("rst_pcs",     pc_start_minus4,        32'h0);
        checkOutput("rst_busy",    {31'b0, busy_o},        32'h0);
        checkOutput("rst_err",     {31'b0, err_o},         32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", {31'b0, host_ready_o}, 32'h1);

        $display("[TB] imem frame N=3 at 0x100");
        applyStimulus(32'h0000_0003);
        checkOutput("t1_busy_hdr", {31'b0, busy_o}, 32'h1);
        applyStimulus(32'h0000_0100);
        checkOutput("t1_nostrobe_addr", {31'b0, imem_wr_valid}, 32'h0);
        applyStimulus(32'hAAAA_0001);
        checkOutput("t1_w0_valid", {31'b0, imem_wr_valid}, 32'h1);
        checkOutput("t1_w0_addr",  imem_wr_addr,           32'h100);
        checkOutput("t1_w0_data",  imem_wr_data,           32'hAAAA_0001);
        checkOutput("t1_w0_dmemv", {31'b0, dmem_wr_valid}, 32'h0);
        applyStimulus(32'hBBBB_0002);
        checkOutput("t1_w1_valid", {31'b0, imem_wr_valid}, 32'h1);
        checkOutput("t1_w1_addr",  imem_wr_addr,           32'h104);
        checkOutput("t1_w1_data",  imem_wr_data,           32'hBBBB_0002);
        applyStimulus(32'hCCCC_0003);
        checkOutput("t1_w2_valid", {31'b0, imem_wr_valid}, 32'h1);
        checkOutput("t1_w2_addr",  imem_wr_addr,           32'h108);
        checkOutput("t1_w2_data",  imem_wr_data,           32'hCCCC_0003);
        checkOutput("t1_w2_dmemv", {31'b0, dmem_wr_valid}, 32'h0);
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'hAAAA_0001 + 32'hBBBB_0002 + 32'hCCCC_0003);
`endif
        idleCycle();
        checkOutput("t1_end_valid", {31'b0, imem_wr_valid}, 32'h0);
        checkOutput("t1_end_busy",  {31'b0, busy_o},        32'h0);
        checkOutput("t1_end_err",   {31'b0, err_o},         32'h0);

        $display("[TB] START at 0x200, then DMEM header halts core");
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0000_0200);
        checkOutput("t2_pcvalid", {31'b0, pc_valid_o}, 32'h1);
        checkOutput("t2_pcs",     pc_start_minus4,     32'h0000_01FC);
        idleCycle();
        idleCycle();
        checkOutput("t2_pcvalid_held", {31'b0, pc_valid_o}, 32'h1);
        applyStimulus(32'h4000_0001);
        checkOutput("t2_pcvalid_drop", {31'b0, pc_valid_o}, 32'h0);
        applyStimulus(32'h0000_0010);
        applyStimulus(32'h0000_0055);
        checkOutput("t2_dmem_valid", {31'b0, dmem_wr_valid}, 32'h1);
        checkOutput("t2_dmem_addr",  dmem_wr_addr,           32'h10);
        checkOutput("t2_dmem_data",  dmem_wr_data,           32'h55);
        checkOutput("t2_imem_quiet", {31'b0, imem_wr_valid}, 32'h0);
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'h0000_0055);
`endif

        $display("[TB] START at 0 and NOP headers");
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0000_0000);
        checkOutput("t5_pcs_wrap", pc_start_minus4,     32'hFFFF_FFFC);
        checkOutput("t5_pcvalid",  {31'b0, pc_valid_o}, 32'h1);
        applyStimulus(32'hC000_0005);
        checkOutput("t5_nop_busy", {31'b0, busy_o}, 32'h0);
        applyStimulus(32'hC000_0005);
        checkOutput("t5_nop_busy2", {31'b0, busy_o},       32'h0);
        checkOutput("t5_nop_imemv", {31'b0, imem_wr_valid}, 32'h0);
        checkOutput("t5_nop_dmemv", {31'b0, dmem_wr_valid}, 32'h0);

        $display("[TB] imem frame N=4 with gaps");
        applyStimulus(32'h0000_0004);
        applyStimulus(32'h0000_0200);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h1000_0000 + 32'(i));
            if (imem_wr_valid) strobeCount++;
            checkOutput("t4_gap_addr", imem_wr_addr, 32'h200 + 32'(4 * i));
            checkOutput("t4_gap_data", imem_wr_data, 32'h1000_0000 + 32'(i));
            idleCycle();
            if (imem_wr_valid) strobeCount++;
        end
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'h4000_0006);
`endif
        idleCycle();
        if (imem_wr_valid) strobeCount++;
        checkOutput("t4_strobes", 32'(strobeCount), 32'd4);
        checkOutput("t4_busy_end", {31'b0, busy_o}, 32'h0);

        $display("[TB] reset in the middle of a data phase");
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0000_0300);
        applyStimulus(32'hDEAD_0001);
        checkOutput("t4r_first", {31'b0, imem_wr_valid}, 32'h1);
        rst = 1'b1;
        host_valid_i = 1'b0;
        #2;
        checkOutput("t4r_async_valid", {31'b0, imem_wr_valid}, 32'h0);
        checkOutput("t4r_async_busy",  {31'b0, busy_o},        32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'h4000_0001);
        checkOutput("t4r_no_stale", {31'b0, imem_wr_valid}, 32'h0);
        applyStimulus(32'h0000_0040);
        applyStimulus(32'h0000_0077);
        checkOutput("t4r_dmem_valid", {31'b0, dmem_wr_valid}, 32'h1);
        checkOutput("t4r_dmem_addr",  dmem_wr_addr,           32'h40);
        checkOutput("t4r_dmem_data",  dmem_wr_data,           32'h77);
        checkOutput("t4r_imem_quiet", {31'b0, imem_wr_valid}, 32'h0);
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'h0000_0077);
`endif

        $display("[TB] misaligned base address");
        checkOutput("mis_err_before", {31'b0, err_o}, 32'h0);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0202);
        checkOutput("mis_err", {31'b0, err_o}, 32'h1);
        applyStimulus(32'h0000_0099);
        checkOutput("mis_valid", {31'b0, imem_wr_valid}, 32'h1);
        checkOutput("mis_addr",  imem_wr_addr,           32'h200);
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'h0000_0099);
`endif
        doReset();
        checkOutput("err_cleared", {31'b0, err_o}, 32'h0);

`ifdef LDR_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0002);
        checkOutput("cs_write", {31'b0, imem_wr_valid}, 32'h1);
        applyStimulus(32'h0000_0003);
        checkOutput("cs_good_err", {31'b0, err_o}, 32'h0);
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0002);
        checkOutput("cs_bad_pre", {31'b0, err_o}, 32'h0);
        applyStimulus(32'h0000_0004);
        checkOutput("cs_bad_err", {31'b0, err_o}, 32'h1);
        doReset();
`endif

        $display("[TB] DMEM range boundary at 0x3FFC");
        applyStimulus(32'h4000_0002);
        applyStimulus(32'h0000_3FFC);
        applyStimulus(32'h0000_0011);
        checkOutput("t3_w0_valid", {31'b0, dmem_wr_valid}, 32'h1);
        checkOutput("t3_w0_addr",  dmem_wr_addr,           32'h3FFC);
        checkOutput("t3_w0_err",   {31'b0, err_o},         32'h0);
        applyStimulus(32'h0000_0022);
        checkOutput("t3_w1_valid", {31'b0, dmem_wr_valid}, 32'h0);
        checkOutput("t3_w1_err",   {31'b0, err_o},         32'h1);
`ifdef LDR_CHECKSUM_EN
        applyStimulus(32'h0000_0033);
`endif
        idleCycle();
        checkOutput("t3_busy_end", {31'b0, busy_o}, 32'h0);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0000_0100);
        checkOutput("t3_start_ignored", {31'b0, pc_valid_o}, 32'h0);
        checkOutput("t3_pcs_unchanged", pc_start_minus4,     32'h0);
        idleCycle();
        checkOutput("t3_err_sticky", {31'b0, err_o}, 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
